// File: rtl/gp_register_file_pkg.sv
// Shared constants and the register-select validity helper for the
// general-purpose register file.
package gp_register_file_pkg;

    localparam int unsigned DATA_W_DEF   = 32'd32;
    localparam int unsigned SEL_W_DEF    = 32'd8;
    localparam int unsigned NUM_REGS_DEF = 32'd256;
    localparam int unsigned ZERO_REG     = 32'd0;

    // A select addresses real storage only if it is nonzero and implemented.
    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned num_regs);
        return (sel != ZERO_REG) && (sel < num_regs);
    endfunction

endpackage

// File: rtl/gp_regfile_read_port.sv
// One registered read port: range check, write-first bypass and output register.
module gp_regfile_read_port
    import gp_register_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] array_data,
    input  logic              wr_ok,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out
);

    logic              sel_ok_s;
    logic [DATA_W-1:0] next_s;
    logic [DATA_W-1:0] data_r;

    assign sel_ok_s = sel_in_range(32'(sel), NUM_REGS);

    // Select the value to capture; wr_ok already excludes register 0.
    always_comb begin
        next_s = {DATA_W{1'b0}};
        if (!sel_ok_s) begin
            next_s = {DATA_W{1'b0}};
        end else if (wr_ok && (wr_sel == sel)) begin
            next_s = wr_data;
        end else begin
            next_s = array_data;
        end
    end

    // Output register, updated only on an enabled read strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            data_r <= next_s;
        end else begin
            data_r <= data_r;
        end
    end

    assign data_out = data_r;

endmodule

// File: rtl/gp_register_file.sv
// General-purpose register file: one write port, two registered read ports,
// register 0 hardwired to zero.
module gp_register_file
    import gp_register_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [SEL_W-1:0]  selectW1,
    input  logic [SEL_W-1:0]  selectR1,
    input  logic [SEL_W-1:0]  selectR2,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] addr,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_ok_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] array_a_s;
    logic [DATA_W-1:0] array_b_s;

    assign wr_ok_s   = EN && write && sel_in_range(32'(selectW1), NUM_REGS);
    assign rd_en_s   = EN && read;
    assign array_a_s = regs_r[selectR1];
    assign array_b_s = regs_r[selectR2];

    // Storage array and write decode; register 0 is never a write target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[selectW1] <= addr;
        end
    end

    gp_regfile_read_port #(
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en_s),
        .sel        (selectR1),
        .array_data (array_a_s),
        .wr_ok      (wr_ok_s),
        .wr_sel     (selectW1),
        .wr_data    (addr),
        .data_out   (outA)
    );

    gp_regfile_read_port #(
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en_s),
        .sel        (selectR2),
        .array_data (array_b_s),
        .wr_ok      (wr_ok_s),
        .wr_sel     (selectW1),
        .wr_data    (addr),
        .data_out   (outB)
    );

endmodule

// File: tb/tb_gp_register_file.sv
// Self-checking bench for gp_register_file: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_gp_register_file;

    localparam int NUM = 256;

    logic        clk;
    logic        rst;
    logic        EN;
    logic [7:0]  selectW1;
    logic [7:0]  selectR1;
    logic [7:0]  selectR2;
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] outA;
    logic [31:0] outB;

    int compared;
    int mismatched;

    logic [31:0] mem [NUM];
    logic [31:0] exp_a;
    logic [31:0] exp_b;

    gp_register_file dut (
        .clk      (clk),
        .rst      (rst),
        .EN       (EN),
        .selectW1 (selectW1),
        .selectR1 (selectR1),
        .selectR2 (selectR2),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .outA     (outA),
        .outB     (outB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input int s, input bit wv, input int ws, input logic [31:0] wd);
        if (s == 0 || s >= NUM) return 32'd0;
        if (wv && s == ws) return wd;
        return mem[s];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM; i++) mem[i] = 32'd0;
        exp_a = 32'd0;
        exp_b = 32'd0;
    endtask

    // Apply one rising edge, advancing the model from the current inputs.
    task automatic tick();
        bit          wv;
        bit          rv;
        logic [31:0] na;
        logic [31:0] nb;
        wv = EN && write && selectW1 != 8'd0 && int'(selectW1) < NUM;
        rv = EN && read;
        na = model_read(int'(selectR1), wv, int'(selectW1), addr);
        nb = model_read(int'(selectR2), wv, int'(selectW1), addr);
        @(posedge clk);
        #1;
        if (rst) begin
            if (wv) mem[selectW1] = addr;
            if (rv) begin
                exp_a = na;
                exp_b = nb;
            end
        end
    endtask

    task automatic idle();
        EN = 1'b1; read = 1'b0; write = 1'b0;
        selectW1 = 8'd0; selectR1 = 8'd0; selectR2 = 8'd0; addr = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            EN = 1'($urandom); read = 1'($urandom); write = 1'($urandom);
            selectW1 = 8'($urandom); selectR1 = 8'($urandom); selectR2 = 8'($urandom);
            addr = $urandom;
            tick();
            compared++;
            if (outA !== 32'd0 || outB !== 32'd0) begin
                $display("FAIL reset_hold cyc%0d: outA=%h outB=%h required 0/0", i, outA, outB);
                mismatched++;
            end
        end
        idle();
        #2 rst = 1'b1;
        selectR1 = 8'd1; selectR2 = 8'd255; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'd0) begin
            $display("FAIL reset_regs: outA=%h outB=%h required 0/0", outA, outB);
            mismatched++;
        end
    endtask

    task automatic test_write_read();
        idle();
        selectW1 = 8'd1; addr = 32'd123; write = 1'b1;
        tick();
        idle();
        selectR1 = 8'd1; selectR2 = 8'd2; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd123 || outB !== 32'd0) begin
            $display("FAIL write_read: outA=%0d outB=%0d required 123/0", outA, outB);
            mismatched++;
        end
    endtask

    task automatic test_second_write_hold();
        idle();
        selectW1 = 8'd3; addr = 32'd456; write = 1'b1;
        tick();
        idle();
        selectR1 = 8'd3; selectR2 = 8'd1; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd456 || outB !== 32'd123) begin
            $display("FAIL second_write: outA=%0d outB=%0d required 456/123", outA, outB);
            mismatched++;
        end
        read = 1'b0;
        selectR1 = 8'd2; selectR2 = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (outA !== 32'd456 || outB !== 32'd123) begin
                $display("FAIL hold cyc%0d: outA=%0d outB=%0d required 456/123", i, outA, outB);
                mismatched++;
            end
        end
    endtask

    task automatic test_reg0();
        idle();
        selectW1 = 8'd0; addr = 32'd123; write = 1'b1;
        tick();
        idle();
        selectR1 = 8'd0; selectR2 = 8'd0; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'd0) begin
            $display("FAIL reg0_protect: outA=%0d outB=%0d required 0/0", outA, outB);
            mismatched++;
        end
    endtask

    task automatic test_enable_bypass();
        idle();
        EN = 1'b0; selectW1 = 8'd5; addr = 32'hDEAD; write = 1'b1;
        selectR1 = 8'd1; selectR2 = 8'd1; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'd0) begin
            $display("FAIL en_gate_hold: outA=%h outB=%h required 0/0", outA, outB);
            mismatched++;
        end
        idle();
        selectR1 = 8'd5; selectR2 = 8'd3; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'd456) begin
            $display("FAIL en_gate_write: outA=%h outB=%0d required 0/456", outA, outB);
            mismatched++;
        end
        idle();
        selectW1 = 8'd7; addr = 32'hBEEF; write = 1'b1;
        selectR1 = 8'd7; selectR2 = 8'd0; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'hBEEF || outB !== 32'd0) begin
            $display("FAIL bypass: outA=%h outB=%h required beef/0", outA, outB);
            mismatched++;
        end
        idle();
        selectW1 = 8'd0; addr = 32'h1234; write = 1'b1;
        selectR1 = 8'd0; selectR2 = 8'd7; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'hBEEF) begin
            $display("FAIL bypass_reg0: outA=%h outB=%h required 0/beef", outA, outB);
            mismatched++;
        end
    endtask

    task automatic test_async_reset();
        idle();
        selectW1 = 8'd4; addr = 32'd99; write = 1'b1;
        tick();
        idle();
        selectR1 = 8'd4; selectR2 = 8'd4; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd99 || outB !== 32'd99) begin
            $display("FAIL pre_reset_read: outA=%0d outB=%0d required 99/99", outA, outB);
            mismatched++;
        end
        selectW1 = 8'd4; addr = 32'd77; write = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        #1;
        compared++;
        if (outA !== 32'd0 || outB !== 32'd0) begin
            $display("FAIL async_reset: outA=%0d outB=%0d required 0/0", outA, outB);
            mismatched++;
        end
        tick();
        idle();
        #2 rst = 1'b1;
        selectR1 = 8'd4; selectR2 = 8'd1; read = 1'b1;
        tick();
        compared++;
        if (outA !== 32'd0 || outB !== 32'd0) begin
            $display("FAIL post_reset_read: outA=%0d outB=%0d required 0/0", outA, outB);
            mismatched++;
        end
    endtask

    function automatic logic [7:0] pick_sel();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        if (r < 8) return 8'($urandom_range(1, 6));
        return 8'($urandom);
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(0, 7) != 0);
            read = 1'($urandom);
            write = 1'($urandom);
            selectW1 = pick_sel();
            selectR1 = pick_sel();
            selectR2 = ($urandom_range(0, 4) == 0) ? selectR1 : pick_sel();
            addr = $urandom;
            tick();
            compared++;
            if (outA !== exp_a || outB !== exp_b) begin
                $display("FAIL random cyc%0d: outA=%h outB=%h required %h/%h", i, outA, outB, exp_a, exp_b);
                mismatched++;
            end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_second_write_hold();
        test_reg0();
        test_enable_bypass();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gp_register_file.md
Name: gp_register_file

Overview:
- General-purpose register file: one write port and two read ports.
- Register 0 is hardwired to zero.
- Sits beside the datapath ALU: supplies two source operands (outA, outB) and accepts one result write per clock.
- Read outputs are registered and update only on an enabled read strobe.

Parameters:
- DATA_W, 32, width of each register and of the data/output buses.
- SEL_W, 8, width of every register-select port.
- NUM_REGS, 256, number of implemented registers; must be ≤ 2**SEL_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; clears all state.
- EN  input  1  block enable; gates both read and write.
- selectW1  input  SEL_W  write register index.
- selectR1  input  SEL_W  read port A register index.
- selectR2  input  SEL_W  read port B register index.
- read  input  1  read strobe; captures both read ports into the outputs.
- write  input  1  write strobe.
- addr  input  DATA_W  write data (the name is kept for compatibility; it carries data, not an address).
- outA  output  DATA_W  registered read data for selectR1.
- outB  output  DATA_W  registered read data for selectR2.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers, outA and outB go to 0 immediately.
  - They hold 0 while rst=0; inputs are ignored.
- Write:
  - At posedge clk, if EN=1, write=1, selectW1≠0 and selectW1<NUM_REGS, then reg[selectW1] ← addr.
  - The new value is visible one cycle later through the array.
- Register 0: writes are silently dropped; it always reads 0.
- Out-of-range index (≥ NUM_REGS): writes are dropped; reads return 0.
- Read:
  - At posedge clk, if EN=1 and read=1, outA ← reg[selectR1] and outB ← reg[selectR2].
  - Latency is one clock from strobe to output.
- Output hold: if read=0 or EN=0, outA and outB hold their last value. Outputs never combinationally follow the selects.
- Simultaneous read and write in the same cycle:
  - Write-first bypass applies: if a read select equals a valid, nonzero selectW1 and the write is enabled, that output captures addr.
  - Bypass never applies to index 0.
- EN=0: no state changes at all, regardless of read/write.
- Both read ports may select the same register; both outputs get the same value.
- Reset asserted mid-operation overrides any pending write or read in that cycle.
- No handshake, no stall; every enabled request completes in its cycle.

Decomposition:
- Shared package holds DATA_W and SEL_W defaults and a ZERO_REG index constant (0).
- One sub-module is natural: gp_regfile_read_port (select/range check, bypass mux, output register), instantiated twice for A and B.
- Storage array and write decode stay in the top level.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random inputs -> outA=outB=0; after release, read reg 1 and reg 255 -> 0.
- Write/read: EN=1, selectW1=1, addr=123, write=1 for 1 cycle; then selectR1=1, selectR2=2, read=1 -> next edge outA=123, outB=0.
- Second write: selectW1=3, addr=456, write; then selectR1=3, selectR2=1, read -> outA=456, outB=123. Drop read -> outputs hold 456/123 over 3 cycles.
- Register 0 protection: selectW1=0, addr=123, write=1; then selectR1=0, read=1 -> outA=0.
- Enable gating and bypass:
  - EN=0, write reg 5=0xDEAD, then EN=1 read reg 5 -> 0.
  - Same cycle: write reg 7=0xBEEF with selectR1=7, read=1 -> outA=0xBEEF.
  - Same cycle with selectR2=0 -> outB=0.
- Async reset mid-op: write reg 4=99 and read it; assert rst=0 between clock edges -> outA drops to 0 without waiting for a clock edge; after release, reg 4 reads 0.
